// File: rtl/cpr_loader.sv
// Streaming .CPR (RIFF "AMS!") parser: strips the container framing and writes
// each "cbNN" chunk payload into its 16 KB cartridge bank in SDRAM.
module cpr_loader #(
  parameter logic [7:0]  CPR_INDEX = 8'd5,
  parameter logic [22:0] BASE_ADDR = 23'h000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wr,
  input  logic        mem_ack,
  output logic        loading,
  output logic        load_done,
  output logic        cart_valid,
  output logic [2:0]  load_error,
  output logic        truncated,
  output logic [31:0] bank_present
);

  typedef enum logic [3:0] {
    S_IDLE, S_RIFF_ID, S_RIFF_LEN, S_FORM_ID, S_CHUNK_ID,
    S_CHUNK_LEN, S_CHUNK_DATA, S_CHUNK_SKIP, S_CHUNK_PAD, S_ERROR
  } state_t;

  localparam logic [31:0] ID_RIFF = 32'h52494646;
  localparam logic [31:0] ID_AMS  = 32'h414D5321;

  state_t       r_state;
  logic [1:0]   r_cnt;
  logic [23:0]  r_word;
  logic [31:0]  r_chunkId;
  logic [23:0]  r_rem;
  logic         r_odd;
  logic [4:0]   r_bank;
  logic [14:0]  r_offset;
  logic         r_memWr;
  logic [22:0]  r_memAddr;
  logic [7:0]   r_memData;
  logic         r_loading;
  logic         r_loadDone;
  logic         r_cartValid;
  logic [2:0]   r_loadErr;
  logic         r_trunc;
  logic [31:0]  r_bankPresent;
  logic         r_endPend;

  logic         w_active;
  logic         w_rise;
  logic         w_fall;
  logic         w_byte;
  logic         w_finish;
  state_t       w_curState;
  logic [1:0]   w_curCnt;
  logic [31:0]  w_word;
  logic [23:0]  w_size;
  logic [6:0]   w_idN;
  logic         w_isBank;
  logic         w_earlyEnd;
  logic [2:0]   w_finalErr;

  state_t       w_stateNext;
  logic [1:0]   w_cntNext;
  logic [23:0]  w_wordNext;
  logic [23:0]  w_remNext;
  logic [2:0]   w_errCode;
  logic         w_doWrite;
  logic         w_discard;
  logic         w_bankDone;
  logic         w_latchId;
  logic         w_latchLen;

  assign w_active = ioctl_download && (ioctl_index == CPR_INDEX);
  assign w_rise   = w_active && !r_loading;
  assign w_fall   = !w_active && r_loading;
  assign w_byte   = w_active && ioctl_wr;
  // A download that ends with a write in flight is only closed once that write is acked
  assign w_finish = (w_fall || r_endPend) && !w_active && (!r_memWr || mem_ack);

  assign w_curState = w_rise ? S_RIFF_ID : r_state;
  assign w_curCnt   = w_rise ? 2'd0 : r_cnt;
  assign w_word     = {r_word, ioctl_dout};
  assign w_size     = {r_word[7:0], r_word[15:8], r_word[23:16]};

  assign w_idN    = ({3'd0, r_chunkId[11:8]} * 7'd10) + {3'd0, r_chunkId[3:0]};
  assign w_isBank = (r_chunkId[31:16] == 16'h6362) &&
                    (r_chunkId[15:8] >= 8'h30) && (r_chunkId[15:8] <= 8'h39) &&
                    (r_chunkId[7:0] >= 8'h30) && (r_chunkId[7:0] <= 8'h39) &&
                    (w_idN < 7'd32);

  assign w_earlyEnd = (r_state == S_CHUNK_DATA) || (r_state == S_CHUNK_SKIP) ||
                      (r_state == S_CHUNK_PAD) || (r_state == S_CHUNK_LEN) ||
                      ((r_state == S_CHUNK_ID) && (r_cnt != 2'd0));
  assign w_finalErr = ((r_loadErr == 3'd0) && w_earlyEnd) ? 3'd5 : r_loadErr;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Byte decode: header fields are 4-byte words, chunk bodies are counted down
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_wordNext  = r_word;
    w_remNext   = r_rem;
    w_errCode   = 3'd0;
    w_doWrite   = 1'b0;
    w_discard   = 1'b0;
    w_bankDone  = 1'b0;
    w_latchId   = 1'b0;
    w_latchLen  = 1'b0;
    if (w_rise) begin
      w_stateNext = S_RIFF_ID;
      w_cntNext   = 2'd0;
    end
    if (w_byte) begin
      if (r_memWr && (w_curState != S_ERROR)) begin
        w_stateNext = S_ERROR;
        w_errCode   = 3'd3;
      end else begin
        w_wordNext = w_word[23:0];
        case (w_curState)
          S_RIFF_ID: begin
            w_cntNext = w_curCnt + 2'd1;
            if (w_curCnt == 2'd3) begin
              if (w_word == ID_RIFF) w_stateNext = S_RIFF_LEN;
              else begin
                w_stateNext = S_ERROR;
                w_errCode   = 3'd1;
              end
            end
          end
          S_RIFF_LEN: begin
            w_cntNext = w_curCnt + 2'd1;
            if (w_curCnt == 2'd3) w_stateNext = S_FORM_ID;
          end
          S_FORM_ID: begin
            w_cntNext = w_curCnt + 2'd1;
            if (w_curCnt == 2'd3) begin
              if (w_word == ID_AMS) w_stateNext = S_CHUNK_ID;
              else begin
                w_stateNext = S_ERROR;
                w_errCode   = 3'd2;
              end
            end
          end
          S_CHUNK_ID: begin
            w_cntNext = w_curCnt + 2'd1;
            if (w_curCnt == 2'd3) begin
              w_latchId   = 1'b1;
              w_stateNext = S_CHUNK_LEN;
            end
          end
          S_CHUNK_LEN: begin
            w_cntNext = w_curCnt + 2'd1;
            if (w_curCnt == 2'd3) begin
              if (ioctl_dout != 8'd0) begin
                w_stateNext = S_ERROR;
                w_errCode   = 3'd4;
              end else begin
                w_latchLen = 1'b1;
                w_remNext  = w_size;
                if (w_size == 24'd0) w_stateNext = S_CHUNK_ID;
                else if (w_isBank)   w_stateNext = S_CHUNK_DATA;
                else                 w_stateNext = S_CHUNK_SKIP;
              end
            end
          end
          S_CHUNK_DATA, S_CHUNK_SKIP: begin
            if (w_curState == S_CHUNK_DATA) begin
              if (!r_offset[14]) w_doWrite = 1'b1;
              else               w_discard = 1'b1;
            end
            w_remNext = r_rem - 24'd1;
            if (r_rem == 24'd1) begin
              w_bankDone  = (w_curState == S_CHUNK_DATA);
              w_stateNext = r_odd ? S_CHUNK_PAD : S_CHUNK_ID;
            end
          end
          S_CHUNK_PAD: w_stateNext = S_CHUNK_ID;
          default: ;
        endcase
      end
    end
    if (w_finish) begin
      w_stateNext = S_IDLE;
      w_cntNext   = 2'd0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_word        <= 24'd0;
      r_chunkId     <= 32'd0;
      r_rem         <= 24'd0;
      r_odd         <= 1'b0;
      r_bank        <= 5'd0;
      r_offset      <= 15'd0;
      r_memWr       <= 1'b0;
      r_memAddr     <= 23'd0;
      r_memData     <= 8'd0;
      r_loading     <= 1'b0;
      r_loadDone    <= 1'b0;
      r_cartValid   <= 1'b0;
      r_loadErr     <= 3'd0;
      r_trunc       <= 1'b0;
      r_bankPresent <= 32'd0;
      r_endPend     <= 1'b0;
    end else begin
      r_loading  <= w_active;
      r_loadDone <= w_finish;
      r_word     <= w_wordNext;
      r_rem      <= w_remNext;
      if (w_rise) begin
        r_loadErr     <= 3'd0;
        r_trunc       <= 1'b0;
        r_bankPresent <= 32'd0;
        r_cartValid   <= 1'b0;
        r_endPend     <= 1'b0;
      end
      if (w_errCode != 3'd0) r_loadErr <= w_errCode;
      if (w_discard)  r_trunc <= 1'b1;
      if (w_bankDone) r_bankPresent[r_bank] <= 1'b1;
      if (w_latchId)  r_chunkId <= w_word;
      if (w_latchLen) begin
        r_odd    <= w_size[0];
        r_bank   <= w_idN[4:0];
        r_offset <= 15'd0;
      end
      if (w_doWrite) begin
        r_memWr   <= 1'b1;
        r_memAddr <= BASE_ADDR + {4'd0, r_bank, r_offset[13:0]};
        r_memData <= ioctl_dout;
        r_offset  <= r_offset + 15'd1;
      end else if (r_memWr && mem_ack) begin
        r_memWr <= 1'b0;
      end
      if (w_fall && !w_finish) r_endPend <= 1'b1;
      if (w_finish) begin
        r_endPend   <= 1'b0;
        r_loadErr   <= w_finalErr;
        r_cartValid <= (w_finalErr == 3'd0) && r_bankPresent[0];
      end
    end
  end

  assign ioctl_wait   = r_memWr;
  assign mem_wr       = r_memWr;
  assign mem_addr     = r_memAddr;
  assign mem_data     = r_memData;
  assign loading      = r_loading;
  assign load_done    = r_loadDone;
  assign cart_valid   = r_cartValid;
  assign load_error   = r_loadErr;
  assign truncated    = r_trunc;
  assign bank_present = r_bankPresent;

endmodule

// File: tb/tb_cpr_loader.sv
// Scoreboard bench for cpr_loader: directed .CPR images, expected SDRAM writes
// are queued by the driver and popped by an SDRAM responder/monitor.
module tb_cpr_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        ioctl_wait;
  logic [22:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr;
  logic        mem_ack = 1'b0;
  logic        loading;
  logic        load_done;
  logic        cart_valid;
  logic [2:0]  load_error;
  logic        truncated;
  logic [31:0] bank_present;

  localparam logic [31:0] ID_RIFF = "RIFF";
  localparam logic [31:0] ID_RIFX = "RIFX";
  localparam logic [31:0] ID_AMS  = "AMS!";
  localparam logic [31:0] ID_AMSQ = "AMS?";
  localparam logic [31:0] ID_FMT  = "fmt ";
  localparam logic [31:0] ID_CB40 = "cb40";

  int          checksTotal = 0;
  int          checksPassed = 0;
  logic [30:0] sbQ[$];
  int          writesSeen = 0;
  int          doneSeen = 0;
  int          waitCycles = 0;
  int          ackDelay = 1;
  logic [22:0] lastAddr = 23'd0;

  cpr_loader #(.CPR_INDEX(8'd5), .BASE_ADDR(23'h000000)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_index(ioctl_index), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .mem_ack(mem_ack),
    .loading(loading), .load_done(load_done), .cart_valid(cart_valid),
    .load_error(load_error), .truncated(truncated), .bank_present(bank_present)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  // SDRAM side: pops the expected write, then acks after ackDelay cycles of mem_wr
  initial begin : responder
    int          cnt;
    bit          busy;
    logic [30:0] e;
    cnt = 0;
    busy = 1'b0;
    forever begin
      @(negedge clk_sys);
      mem_ack = 1'b0;
      if (ioctl_wait) waitCycles++;
      if (load_done) doneSeen++;
      if (mem_wr && !busy) begin
        writesSeen++;
        lastAddr = mem_addr;
        busy = 1'b1;
        cnt = ackDelay - 1;
        if (sbQ.size() == 0) begin
          checksTotal++;
          $display("[TB] FAIL unexpected_write: actual addr 0x%0h data 0x%0h, required no write", mem_addr, mem_data);
        end else begin
          e = sbQ.pop_front();
          checkOutput("write_addr_data", {1'b0, mem_addr, mem_data}, {1'b0, e});
        end
      end
      if (busy) begin
        if (cnt == 0) begin
          mem_ack = 1'b1;
          busy = 1'b0;
        end else cnt--;
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while (ioctl_wait && n < 64) begin
      @(negedge clk_sys);
      n++;
    end
    if (ioctl_wait) begin
      checksTotal++;
      $display("[TB] FAIL wait_timeout: actual ioctl_wait 1 required 0 within 64 cycles");
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    ioctl_dout = b;
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    waitIdle();
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) applyStimulus(w[i*8 +: 8]);
  endtask

  task automatic sendLen(input logic [31:0] n);
    for (int i = 0; i < 4; i++) applyStimulus(n[i*8 +: 8]);
  endtask

  task automatic sendHeader(input logic [31:0] riffId, input logic [31:0] formId);
    sendWord(riffId);
    sendLen(32'd0);
    sendWord(formId);
  endtask

  task automatic sendChunk(input int bankN, input int size, input int sendCount, input logic [7:0] seed);
    logic [31:0] id;
    logic [7:0]  b;
    logic [22:0] a;
    id = {16'h6362, 8'h30 + 8'(bankN / 10), 8'h30 + 8'(bankN % 10)};
    sendWord(id);
    sendLen(32'(size));
    for (int i = 0; i < sendCount; i++) begin
      b = 8'(i) + seed;
      if (i < 16384) begin
        a = 23'(bankN * 16384 + i);
        sbQ.push_back({a, b});
      end
      applyStimulus(b);
    end
  endtask

  task automatic startLoad();
    writesSeen = 0;
    doneSeen = 0;
    @(negedge clk_sys);
    ioctl_index = 8'd5;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic endLoad(input string tag, input int expWrites, input logic [2:0] expErr,
                         input logic expCart, input logic [31:0] expBanks, input logic expTrunc);
    ioctl_download = 1'b0;
    repeat (10) @(negedge clk_sys);
    checkOutput({tag, "_done_count"}, doneSeen, 1);
    checkOutput({tag, "_writes"}, writesSeen, expWrites);
    checkOutput({tag, "_sb_left"}, sbQ.size(), 0);
    checkOutput({tag, "_load_error"}, load_error, expErr);
    checkOutput({tag, "_cart_valid"}, cart_valid, expCart);
    checkOutput({tag, "_bank_present"}, bank_present, expBanks);
    checkOutput({tag, "_truncated"}, truncated, expTrunc);
    checkOutput({tag, "_loading"}, loading, 0);
  endtask

  initial begin : main
    repeat (3) @(negedge clk_sys);
    checkOutput("rst_mem_wr", mem_wr, 0);
    checkOutput("rst_ioctl_wait", ioctl_wait, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_data", mem_data, 0);
    checkOutput("rst_loading", loading, 0);
    checkOutput("rst_load_done", load_done, 0);
    checkOutput("rst_cart_valid", cart_valid, 0);
    checkOutput("rst_load_error", load_error, 0);
    checkOutput("rst_truncated", truncated, 0);
    checkOutput("rst_bank_present", bank_present, 0);
    reset = 1'b0;

    $display("[TB] valid image");
    startLoad();
    checkOutput("valid_loading", loading, 1);
    sendHeader(ID_RIFF, ID_AMS);
    sendChunk(0, 16384, 16384, 8'h00);
    sendChunk(1, 4, 4, 8'hA0);
    endLoad("valid", 16388, 3'd0, 1'b1, 32'h3, 1'b0);
    checkOutput("valid_last_addr", lastAddr, 23'h004003);

    $display("[TB] odd chunk and unknown chunk");
    startLoad();
    sendHeader(ID_RIFF, ID_AMS);
    sendChunk(5, 3, 3, 8'h41);
    applyStimulus(8'hEE);
    sendWord(ID_FMT);
    sendLen(32'd6);
    for (int i = 0; i < 6; i++) applyStimulus(8'(8'h90 + i));
    endLoad("odd", 3, 3'd0, 1'b0, 32'h20, 1'b0);
    checkOutput("odd_last_addr", lastAddr, 23'h014002);

    $display("[TB] header errors");
    startLoad();
    sendHeader(ID_RIFX, ID_AMS);
    endLoad("riffx", 0, 3'd1, 1'b0, 32'h0, 1'b0);
    startLoad();
    sendHeader(ID_RIFF, ID_AMSQ);
    sendChunk(0, 2, 0, 8'h00);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    endLoad("amsq", 0, 3'd2, 1'b0, 32'h0, 1'b0);

    $display("[TB] oversize chunk");
    startLoad();
    sendHeader(ID_RIFF, ID_AMS);
    sendChunk(2, 16386, 16386, 8'h33);
    checkOutput("over_truncated_mid", truncated, 1);
    sendWord(ID_CB40);
    sendLen(32'd2);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    endLoad("over", 16384, 3'd0, 1'b0, 32'h4, 1'b1);
    checkOutput("over_last_addr", lastAddr, 23'h00BFFF);

    $display("[TB] delayed ack with overrun");
    startLoad();
    sendHeader(ID_RIFF, ID_AMS);
    sendChunk(0, 4, 0, 8'h00);
    ackDelay = 5;
    waitCycles = 0;
    sbQ.push_back({23'h000000, 8'h5A});
    ioctl_dout = 8'h5A;
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    ioctl_dout = 8'h5B;
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    waitIdle();
    repeat (3) @(negedge clk_sys);
    checkOutput("hs_wait_cycles", waitCycles, 5);
    checkOutput("hs_error_live", load_error, 3);
    endLoad("hs", 1, 3'd3, 1'b0, 32'h0, 1'b0);
    ackDelay = 1;

    $display("[TB] early end");
    startLoad();
    sendHeader(ID_RIFF, ID_AMS);
    sendChunk(0, 1000, 100, 8'h07);
    endLoad("early", 100, 3'd5, 1'b0, 32'h0, 1'b0);

    $display("[TB] reset mid-load");
    startLoad();
    sendHeader(ID_RIFF, ID_AMS);
    sendChunk(3, 2, 2, 8'h10);
    checkOutput("rml_bank_before", bank_present, 32'h8);
    sendChunk(0, 10, 0, 8'h00);
    ackDelay = 5;
    sbQ.push_back({23'h000000, 8'h77});
    ioctl_dout = 8'h77;
    ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    checkOutput("rml_mem_wr_pending", mem_wr, 1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    checkOutput("rml_mem_wr", mem_wr, 0);
    checkOutput("rml_ioctl_wait", ioctl_wait, 0);
    checkOutput("rml_mem_addr", mem_addr, 0);
    checkOutput("rml_mem_data", mem_data, 0);
    checkOutput("rml_loading", loading, 0);
    checkOutput("rml_bank_present", bank_present, 0);
    checkOutput("rml_load_error", load_error, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk_sys);
    checkOutput("rml_no_done", doneSeen, 0);
    checkOutput("rml_sb_left", sbQ.size(), 0);
    ackDelay = 1;

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
